// File: rtl/fetch_ctrl_n.sv
// Fetch PC controller for FETCH_W lanes with back-pressure stall, flush redirect
// bubble, and a ring allocator of branch IDs tracked by per-tag busy bits.
module fetch_ctrl_n #(
  parameter int FETCH_W         = 2,
  parameter int PC_W            = 5,
  parameter int BID_W           = 3,
  parameter int REDIRECT_BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iq_full,
  input  logic                     buffer_full,
  input  logic [FETCH_W-1:0]       dec_branch,
  input  logic                     flush,
  input  logic [BID_W-1:0]         flush_bid,
  input  logic [PC_W-1:0]          flush_addr,
  input  logic                     resolve_vld,
  input  logic [BID_W-1:0]         resolve_bid,
  output logic [PC_W-1:0]          pc,
  output logic [FETCH_W-1:0]       fetch_vld,
  output logic [FETCH_W*BID_W-1:0] alloc_bid,
  output logic                     bid_full,
  output logic [1:0]               state
);

  localparam int NUM_BID = 1 << BID_W;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [PC_W-1:0]            pc_q, pc_d;
  logic [BID_W-1:0]           ptr_q, ptr_d;
  logic [NUM_BID-1:0]         busy_q, busy_d;
  logic [FETCH_W*BID_W-1:0]   lane_bid;
  logic [BID_W-1:0]           need_bid;
  logic                       tags_ok;
  logic                       accept;

  // Branch lanes take consecutive tags from alloc_ptr in lane order.
  always_comb begin : tag_calc
    int need;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    need     = 0;
    lane_bid = '0;
    tags_ok  = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (dec_branch[i]) begin
        lane_bid[i*BID_W +: BID_W] = ptr_q + BID_W'(need);
        need = need + 1;
      end
    end
    for (int k = 0; k < FETCH_W; k++) begin
      if (k < need && busy_q[ptr_q + BID_W'(k)]) tags_ok = 1'b0;
    end
    need_bid = BID_W'(need);
  end

  assign accept = (state_q != REDIRECT) & ~flush & ~iq_full & ~buffer_full & tags_ok;

  always_comb begin : next_data
    logic [BID_W-1:0] span;
    logic [BID_W-1:0] off;
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    busy_d = busy_q;
    span   = ptr_q - flush_bid;
    off    = '0;
    if (resolve_vld) busy_d[resolve_bid] = 1'b0;
    if (flush) begin
      pc_d  = flush_addr;
      ptr_d = flush_bid;
      // Release the flushed tag and all younger ones: circular distance below span.
      for (int i = 0; i < NUM_BID; i++) begin
        off = BID_W'(i) - flush_bid;
        if (off < span) busy_d[i] = 1'b0;
      end
    end else if (accept) begin
      pc_d  = pc_q + PC_W'(FETCH_W);
      ptr_d = ptr_q + need_bid;
      for (int i = 0; i < FETCH_W; i++) begin
        if (dec_branch[i]) busy_d[lane_bid[i*BID_W +: BID_W]] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      if (REDIRECT_BUBBLE == 0) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = REDIRECT;
        cnt_d   = 3'(REDIRECT_BUBBLE);
      end
    end else begin
      case (state_q)
        RUN:   if (!accept) state_d = STALL;
        STALL: if (accept)  state_d = RUN;
        REDIRECT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin : outputs
    fetch_vld = '0;
    alloc_bid = '0;
    bid_full  = 1'b0;
    if (!rst) begin
      fetch_vld = {FETCH_W{accept}};
      alloc_bid = accept ? lane_bid : '0;
      bid_full  = (state_q != REDIRECT) & ~tags_ok;
    end
  end

  // NOTE: the busy bits are plain flops, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_fetch_ctrl_n.sv
// Randomized and directed bench for fetch_ctrl_n against a cycle-level model
// built from tag-ring and pc arithmetic.
module tb_fetch_ctrl_n;

  localparam int FW  = 2;
  localparam int PW  = 5;
  localparam int BW  = 3;
  localparam int BUB = 1;
  localparam int NB  = 1 << BW;
  localparam int PCM = 1 << PW;

  logic            clk = 1'b0;
  logic            rst, iq_full, buffer_full, flush, resolve_vld;
  logic [FW-1:0]   dec_branch;
  logic [BW-1:0]   flush_bid, resolve_bid;
  logic [PW-1:0]   flush_addr;
  logic [PW-1:0]   pc;
  logic [FW-1:0]   fetch_vld;
  logic [FW*BW-1:0] alloc_bid;
  logic            bid_full;
  logic [1:0]      state;

  fetch_ctrl_n #(.FETCH_W(FW), .PC_W(PW), .BID_W(BW), .REDIRECT_BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .iq_full(iq_full), .buffer_full(buffer_full),
    .dec_branch(dec_branch), .flush(flush), .flush_bid(flush_bid),
    .flush_addr(flush_addr), .resolve_vld(resolve_vld), .resolve_bid(resolve_bid),
    .pc(pc), .fetch_vld(fetch_vld), .alloc_bid(alloc_bid), .bid_full(bid_full),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 run, 1 stalled, 2 redirect bubble
  int m_pc, m_ptr, m_mode, m_cnt;
  bit m_busy[NB];
  bit m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input bit r, input bit iq, input bit bf, input logic [FW-1:0] dec,
                      input bit fl, input int fbid, input int faddr,
                      input bit rv, input int rbid);
    int need, j, k;
    bit ok, acc, red;
    logic [FW*BW-1:0] eb;
    @(negedge clk);
    rst = r; iq_full = iq; buffer_full = bf; dec_branch = dec; flush = fl;
    flush_bid = BW'(fbid); flush_addr = PW'(faddr);
    resolve_vld = rv; resolve_bid = BW'(rbid);
    #1;
    need = 0;
    for (int i = 0; i < FW; i++) if (dec[i]) need++;
    ok = 1'b1;
    for (int q = 0; q < need; q++) if (m_busy[(m_ptr + q) % NB]) ok = 1'b0;
    red = (m_mode == 2);
    acc = !red && !fl && !iq && !bf && ok;
    eb = '0;
    j = 0;
    for (int i = 0; i < FW; i++) begin
      if (dec[i]) begin
        if (acc) eb[i*BW +: BW] = BW'((m_ptr + j) % NB);
        j++;
      end
    end
    if (m_known) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("state", 32'(state), 32'(m_mode));
    end
    if (r) begin
      check("rst_vld", 32'(fetch_vld), 32'd0);
      check("rst_bid", 32'(alloc_bid), 32'd0);
      check("rst_full", 32'(bid_full), 32'd0);
    end else begin
      check("fetch_vld", 32'(fetch_vld), acc ? 32'((1 << FW) - 1) : 32'd0);
      check("alloc_bid", 32'(alloc_bid), 32'(eb));
      check("bid_full", 32'(bid_full), 32'(!red && !ok));
    end
    if (r) begin
      m_pc = 0; m_ptr = 0; m_mode = 0; m_cnt = 0; m_known = 1'b1;
      for (int i = 0; i < NB; i++) m_busy[i] = 1'b0;
    end else begin
      if (rv) m_busy[rbid] = 1'b0;
      if (fl) begin
        k = fbid;
        while (k != m_ptr) begin
          m_busy[k] = 1'b0;
          k = (k + 1) % NB;
        end
        m_pc = faddr; m_ptr = fbid;
        m_mode = (BUB == 0) ? 0 : 2;
        m_cnt = BUB;
      end else if (red) begin
        if (m_cnt == 1) m_mode = 0;
        m_cnt--;
      end else begin
        if (acc) begin
          j = 0;
          for (int i = 0; i < FW; i++) if (dec[i]) begin
            m_busy[(m_ptr + j) % NB] = 1'b1;
            j++;
          end
          m_pc = (m_pc + FW) % PCM;
          m_ptr = (m_ptr + need) % NB;
        end
        m_mode = acc ? 0 : 1;
      end
    end
  endtask

  task automatic idle(input logic [FW-1:0] dec);
    step(0, 0, 0, dec, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset, then free-running fetch with no branches
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2'b11, 1, 3, 9, 1, 2);
    repeat (4) idle(2'b00);
    check("t1_pc", 32'(pc), 32'd6);
    // Back-pressure from both sources
    step(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    check("t2_state", 32'(state), 32'd1);
    idle(2'b00);
    idle(2'b00);

    // Exhaust all tags, then release them one at a time
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) idle(2'b11);
    idle(2'b11);
    check("t3_full", 32'(bid_full), 32'd1);
    step(0, 0, 0, 2'b11, 0, 0, 0, 1, 0);
    step(0, 0, 0, 2'b11, 0, 0, 0, 1, 1);
    check("t3_resolve_same_cycle", 32'(fetch_vld), 32'd0);
    idle(2'b11);
    check("t3_realloc", 32'(alloc_bid), 32'(6'o10));

    // Flush rewinds allocator from ptr 6 back to tag 2
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle(2'b11);
    step(0, 0, 0, 2'b11, 1, 2, 17, 0, 0);
    idle(2'b11);
    check("t4_pc", 32'(pc), 32'd17);
    check("t4_redirect", 32'(state), 32'd2);
    idle(2'b11);
    check("t4_alloc", 32'(alloc_bid), 32'(6'o32));

    // Flush with resolve in the same cycle, then pc wrap
    step(0, 0, 0, 2'b01, 1, 4, 30, 1, 0);
    idle(2'b00);
    idle(2'b01);
    idle(2'b00);
    check("t5_wrap", 32'(pc), 32'd0);

    // Reset in the middle of a redirect bubble
    step(0, 0, 0, 2'b00, 1, 1, 11, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    idle(2'b00);
    check("t6_pc", 32'(pc), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 200) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
           FW'($urandom), ($urandom % 20) == 0, int'($urandom % NB), int'($urandom % PCM),
           ($urandom % 2) == 0, int'($urandom % NB));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
